// File: rtl/wrr_deq_scheduler_if.sv
// Signal bundle between the WRR dequeue scheduler, the queue RAMs/owner and
// the downstream packet consumer. The scheduler takes the master side.
interface wrr_deq_scheduler_if #(
    parameter int NMB_QUES = 4,
    parameter int SEL_W    = 2,
    parameter int WEIGHT_W = 3
);
    logic                         sched_en;
    logic [NMB_QUES-1:0]          que_nonempty;
    logic [NMB_QUES*WEIGHT_W-1:0] weight_flat;
    logic [NMB_QUES*64-1:0]       q_flat;
    logic                         out_ready;
    logic [SEL_W-1:0]             que_sel;
    logic [63:0]                  data_out;
    logic                         valid_data_out;
    logic                         deq_pulse;
    logic                         busy;

    modport master (
        input  sched_en, que_nonempty, weight_flat, q_flat, out_ready,
        output que_sel, data_out, valid_data_out, deq_pulse, busy
    );

    modport slave (
        output sched_en, que_nonempty, weight_flat, q_flat, out_ready,
        input  que_sel, data_out, valid_data_out, deq_pulse, busy
    );
endinterface

// File: rtl/wrr_deq_scheduler.sv
// Weighted round-robin dequeue scheduler. Picks a queue, waits out the RAM
// read latency, presents one 64-bit packet word with valid/ready, then strobes
// deq_pulse so the queue owner advances that queue. Each queue is served up to
// its weight (0 counts as 1) before the search moves upward to the next
// nonempty queue.
module wrr_deq_scheduler #(
    parameter int NMB_QUES = 4,
    parameter int SEL_W    = 2,
    parameter int WEIGHT_W = 3,
    parameter int RD_LAT   = 2
) (
    input  logic                clk_div_8,
    input  logic                reset_n,
    wrr_deq_scheduler_if.master bus
);
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        READ    = 3'd2,
        PRESENT = 3'd3,
        ADV     = 3'd4
    } state_t;

    state_t              state_q,  state_d;
    logic [SEL_W-1:0]    que_sel_q, que_sel_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [63:0]         data_q,   data_d;

    // Per-queue views of the flat buses, plus the candidate list in search
    // order: entry k is queue que_sel+1+k, so the current queue is last.
    logic [WEIGHT_W-1:0] weight_arr [NMB_QUES];
    logic [63:0]         q_arr      [NMB_QUES];
    logic [SEL_W-1:0]    cand_idx   [NMB_QUES];
    logic [NMB_QUES-1:0] cand_ne;

    logic                found;
    logic [SEL_W-1:0]    next_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NMB_QUES; gi++) begin : g_que
            assign weight_arr[gi] = bus.weight_flat[gi*WEIGHT_W +: WEIGHT_W];
            assign q_arr[gi]      = bus.q_flat[gi*64 +: 64];
            assign cand_idx[gi]   = que_sel_q + SEL_W'(gi + 1);
            assign cand_ne[gi]    = bus.que_nonempty[cand_idx[gi]];
        end
    endgenerate

    // First nonempty queue above que_sel, wrapping; lowest search slot wins.
    always_comb begin
        found    = 1'b0;
        next_idx = que_sel_q;
        for (int k = NMB_QUES - 1; k >= 0; k--) begin
            if (cand_ne[k]) begin
                found    = 1'b1;
                next_idx = cand_idx[k];
            end
        end
    end

    // Next-state, queue selection, credit accounting and data capture.
    always_comb begin
        state_d   = state_q;
        que_sel_d = que_sel_q;
        credit_d  = credit_q;
        rd_cnt_d  = rd_cnt_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (bus.sched_en && (|bus.que_nonempty)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!bus.sched_en || !found) begin
                    state_d = IDLE;
                end else begin
                    state_d  = READ;
                    rd_cnt_d = '0;
                    // Stay on the current queue only while it still has credit
                    // and packets; otherwise move on and reload from its weight.
                    if (!((credit_q != '0) && bus.que_nonempty[que_sel_q])) begin
                        que_sel_d = next_idx;
                        credit_d  = (weight_arr[next_idx] == '0) ? WEIGHT_W'(1)
                                                                 : weight_arr[next_idx];
                    end
                end
            end
            READ: begin
                if (rd_cnt_q == CNT_W'(RD_LAT - 1)) begin
                    data_d  = q_arr[que_sel_q];
                    state_d = PRESENT;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                end
                state_d = ARB;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_div_8) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            que_sel_q <= SEL_W'(NMB_QUES - 1);
            credit_q  <= '0;
            rd_cnt_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            que_sel_q <= que_sel_d;
            credit_q  <= credit_d;
            rd_cnt_q  <= rd_cnt_d;
            data_q    <= data_d;
        end
    end

    assign bus.que_sel        = que_sel_q;
    assign bus.data_out       = data_q;
    assign bus.valid_data_out = (state_q == PRESENT);
    // Gated by reset so a reset landing on the ADV cycle withdraws the dequeue
    // on that same edge and the packet stays queued.
    assign bus.deq_pulse      = (state_q == ADV) && reset_n;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_wrr_deq_scheduler.sv
// Randomized scoreboard bench for wrr_deq_scheduler. A packet-level WRR model
// predicts the served queue and data word of each packet; a monitor pops and
// compares on every accepted transfer and checks the deq_pulse timing.
module tb_wrr_deq_scheduler;
    localparam int NQ       = 4;
    localparam int SEL_W    = 2;
    localparam int WEIGHT_W = 3;
    localparam int RD_LAT   = 2;

    typedef struct {
        int          q;
        logic [63:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wrr_deq_scheduler_if #(.NMB_QUES(NQ), .SEL_W(SEL_W), .WEIGHT_W(WEIGHT_W)) bus ();

    wrr_deq_scheduler #(
        .NMB_QUES(NQ), .SEL_W(SEL_W), .WEIGHT_W(WEIGHT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk_div_8 (clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    exp_t                exp_q[$];
    int                  base_cnt [NQ];
    int                  deq_cnt  [NQ];
    logic [WEIGHT_W-1:0] w_cur    [NQ];
    int                  sc_cnt   [NQ];
    int                  sc_w     [NQ];
    logic [31:0]         tag = 32'h0;
    int                  n_chk = 0;
    int                  n_pass = 0;
    int                  acc_cnt = 0;
    int                  scen_id = 0;
    bit                  gap_en = 1'b0;

    // Packet word: scenario tag, packets left in the queue, queue id.
    function automatic logic [63:0] word(input int q, input int rem);
        return {tag, 16'(rem), 8'h00, 8'(8'hA0 + q)};
    endfunction

    // Queue owner: occupancy is loaded count minus observed dequeues.
    always_comb begin
        bus.que_nonempty = '0;
        bus.weight_flat  = '0;
        bus.q_flat       = '0;
        for (int i = 0; i < NQ; i++) begin
            bus.que_nonempty[i] = (base_cnt[i] > deq_cnt[i]);
            bus.weight_flat[i*WEIGHT_W +: WEIGHT_W] = w_cur[i];
            bus.q_flat[i*64 +: 64] = word(i, base_cnt[i] - deq_cnt[i]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packet-level reference: serve the current queue while it has credit and
    // packets, else the next nonempty queue upward with credit = max(weight,1).
    task automatic build_model(input int chg_at, input int chg_q, input int chg_w,
                               input int maxp, output int n);
        int c [NQ];
        int w [NQ];
        int cur, cred, total;
        exp_t e;
        cur = NQ - 1;
        cred = 0;
        n = 0;
        for (int i = 0; i < NQ; i++) begin
            c[i] = sc_cnt[i];
            w[i] = sc_w[i];
        end
        for (int it = 0; it < maxp; it++) begin
            total = 0;
            for (int i = 0; i < NQ; i++) total += c[i];
            if (total == 0) break;
            if (n == chg_at) w[chg_q] = chg_w;
            if (cred == 0 || c[cur] == 0) begin
                for (int k = 1; k <= NQ; k++) begin
                    if (c[(cur + k) % NQ] > 0) begin
                        cur = (cur + k) % NQ;
                        break;
                    end
                end
                cred = (w[cur] == 0) ? 1 : w[cur];
            end
            e.q = cur;
            e.d = word(cur, c[cur]);
            exp_q.push_back(e);
            c[cur]--;
            cred--;
            n++;
        end
    endtask

    task automatic do_reset();
        bus.sched_en  = 1'b0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        repeat (2) step();
        reset_n       = 1'b1;
    endtask

    task automatic load_scen();
        exp_q.delete();
        tag = $urandom;
        scen_id++;
        for (int i = 0; i < NQ; i++) begin
            w_cur[i]    = WEIGHT_W'(sc_w[i]);
            base_cnt[i] = deq_cnt[i] + sc_cnt[i];
        end
    endtask

    task automatic wait_done(input string name, input int chg_at, input int chg_q,
                             input int chg_w, input bit rnd_rdy);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 4000 && !done; t++) begin
            step();
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            if (chg_at >= 0 && acc_cnt >= chg_at) w_cur[chg_q] = WEIGHT_W'(chg_w);
            done = (exp_q.size() == 0) && !bus.busy;
        end
        chk({name, "_done"}, done, 1);
    endtask

    task automatic run_scen(input string name, input int chg_at, input int chg_q,
                            input int chg_w, input bit rnd_rdy, input bit gap);
        int n_exp, acc0;
        do_reset();
        load_scen();
        build_model(chg_at, chg_q, chg_w, 1000, n_exp);
        acc0          = acc_cnt;
        gap_en        = gap;
        bus.sched_en  = 1'b1;
        wait_done(name, (chg_at >= 0) ? acc0 + chg_at : -1, chg_q, chg_w, rnd_rdy);
        chk({name, "_count"}, acc_cnt - acc0, n_exp);
        gap_en        = 1'b0;
        bus.sched_en  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Monitor: scoreboard pops on accepted transfers, deq_pulse must follow
    // each acceptance by exactly one cycle, data must hold under backpressure.
    initial begin
        exp_t        e;
        bit          acc_prev, prev_hold;
        logic [63:0] prev_data;
        int          cyc, last_deq_cyc, last_deq_scen;
        acc_prev = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        cyc = 0;
        last_deq_cyc = 0;
        last_deq_scen = -1;
        for (int i = 0; i < NQ; i++) deq_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.deq_pulse === 1'b1 || acc_prev) chk("deq_pulse", bus.deq_pulse, acc_prev);
            if (bus.deq_pulse === 1'b1) begin
                deq_cnt[bus.que_sel]++;
                if (gap_en && last_deq_scen == scen_id)
                    chk("deq_gap", cyc - last_deq_cyc, RD_LAT + 3);
                last_deq_cyc  = cyc;
                last_deq_scen = scen_id;
            end
            if (prev_hold && bus.valid_data_out === 1'b1) chk("hold_data", bus.data_out, prev_data);
            acc_prev  = 1'b0;
            prev_hold = 1'b0;
            if (bus.valid_data_out === 1'b1) begin
                if (bus.out_ready) begin
                    acc_prev = 1'b1;
                    acc_cnt++;
                    $display("pkt %0d: que_sel=%0d data=%h", acc_cnt, bus.que_sel, bus.data_out);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_pkt: got que_sel %0d, expected no packet", bus.que_sel);
                    end else begin
                        e = exp_q.pop_front();
                        chk("que_sel", bus.que_sel, e.q);
                        chk("data_out", bus.data_out, e.d);
                    end
                end else begin
                    prev_hold = 1'b1;
                    prev_data = bus.data_out;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int          n, d_before, t_busy, t_valid;
        logic [63:0] held;
        bit          seen;
        for (int i = 0; i < NQ; i++) begin
            base_cnt[i] = $urandom_range(0, 3);
            w_cur[i]    = WEIGHT_W'(i + 1);
        end
        bus.out_ready = 1'b1;
        bus.sched_en  = 1'($urandom_range(0, 1));
        reset_n       = 1'b0;

        // Reset with random occupancy, then release with every queue empty.
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rst_valid", bus.valid_data_out, 0);
            chk("rst_deq", bus.deq_pulse, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_data", bus.data_out, 0);
        end
        chk("rst_que_sel", bus.que_sel, NQ - 1);
        for (int i = 0; i < NQ; i++) base_cnt[i] = 0;
        bus.sched_en = 1'b1;
        reset_n      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("empty_idle", bus.busy, 0);
        end

        // Weighted round, default weights, 10 packets each.
        for (int i = 0; i < NQ; i++) begin sc_cnt[i] = 10; sc_w[i] = i + 1; end
        run_scen("wrr", -1, 0, 0, 1'b0, 1'b1);

        // Only queues 1 and 3 hold packets.
        sc_cnt = '{0, 6, 0, 3};
        sc_w   = '{1, 2, 3, 1};
        run_scen("skip", -1, 0, 0, 1'b0, 1'b1);

        // Weight 0 on queue 2, queue 3 drops from 4 to 1 mid-round.
        sc_cnt = '{8, 8, 8, 8};
        sc_w   = '{1, 2, 0, 4};
        run_scen("wchg", 5, 3, 1, 1'b0, 1'b1);

        // Random occupancy, weights, weight change and consumer stalls.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NQ; i++) begin
                sc_cnt[i] = $urandom_range(0, 6);
                sc_w[i]   = $urandom_range(0, 7);
            end
            run_scen("rand", $urandom_range(0, 6), $urandom_range(0, NQ - 1),
                     $urandom_range(0, 7), 1'b1, 1'b0);
        end

        // Backpressure: 7 stalled cycles in PRESENT.
        do_reset();
        sc_cnt = '{0, 0, 2, 0};
        sc_w   = '{1, 2, 3, 4};
        load_scen();
        build_model(-1, 0, 0, 1000, n);
        bus.out_ready = 1'b0;
        bus.sched_en  = 1'b1;
        t_busy = -1;
        t_valid = -1;
        for (int t = 0; t < 50 && t_valid < 0; t++) begin
            step();
            if (bus.busy && t_busy < 0) t_busy = t;
            if (bus.valid_data_out) t_valid = t;
        end
        chk("latency", t_valid - t_busy, RD_LAT + 1);
        held = bus.data_out;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("bp_valid", bus.valid_data_out, 1);
            chk("bp_data", bus.data_out, held);
        end
        bus.out_ready = 1'b1;
        wait_done("bp", -1, 0, 0, 1'b0);
        bus.sched_en = 1'b0;

        // Drop sched_en during READ: packet completes, then idle.
        do_reset();
        sc_cnt = '{3, 0, 0, 0};
        load_scen();
        build_model(-1, 0, 0, 1, n);
        d_before = deq_cnt[0];
        bus.sched_en = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            seen = bus.busy;
        end
        chk("en_start", seen, 1);
        step();
        bus.sched_en = 1'b0;
        wait_done("en_drop", -1, 0, 0, 1'b0);
        repeat (6) step();
        chk("en_idle", bus.busy, 0);
        chk("en_deq_cnt", deq_cnt[0] - d_before, 1);

        // Reset during PRESENT: no dequeue, queue 0 served first afterwards.
        do_reset();
        sc_cnt = '{2, 2, 0, 0};
        sc_w   = '{1, 2, 3, 4};
        load_scen();
        d_before = deq_cnt[0] + deq_cnt[1];
        bus.out_ready = 1'b0;
        bus.sched_en  = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            seen = bus.valid_data_out;
        end
        chk("pr_valid", seen, 1);
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("pr_rst_valid", bus.valid_data_out, 0);
            chk("pr_rst_busy", bus.busy, 0);
        end
        chk("pr_no_deq", deq_cnt[0] + deq_cnt[1], d_before);
        build_model(-1, 0, 0, 1000, n);
        bus.out_ready = 1'b1;
        reset_n = 1'b1;
        wait_done("pr_after", -1, 0, 0, 1'b0);
        bus.sched_en = 1'b0;

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
